// File: rtl/fp_result_pack.sv
// Re-encodes FP16 accumulator results to FP8 (E4M3 or E5M2), or passes raw FP16
// through as two bytes, onto a valid/ready byte stream.
module fp_result_pack #(
  parameter logic [7:0] NAN_CANON = 8'h7F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        fmt,
  input  logic        wide,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {S_IDLE, S_BYTE, S_HI, S_LO} state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic              r_out_last;
  logic [7:0]        r_out_data;
  logic [7:0]        r_lo;

  logic              w_sign;
  logic [4:0]        w_exp16;
  logic [9:0]        w_man16;
  logic [3:0]        w_lead;
  logic [10:0]       w_sig;
  logic signed [7:0] w_unb;
  logic signed [7:0] w_te;
  logic [4:0]        w_sh;
  logic [31:0]       w_ext;
  logic [5:0]        w_ef;
  logic              w_rnd4;
  logic              w_rnd5;
  logic [8:0]        w_q4;
  logic [7:0]        w_q5;
  logic [7:0]        w_fp8;
  logic              w_accept;
  logic              w_xfer;

  assign w_sign  = in_data[15];
  assign w_exp16 = in_data[14:10];
  assign w_man16 = in_data[9:0];

  always_comb begin
    w_lead = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_man16[i]) w_lead = i[3:0];
    end
    // FP16 subnormals are normalized so the hidden bit always sits at w_sig[10]
    if (w_exp16 == 5'd0) begin
      w_sig = {1'b0, w_man16} << (4'd10 - w_lead);
      w_unb = $signed({4'b0, w_lead}) - 8'sd24;
    end else begin
      w_sig = {1'b1, w_man16};
      w_unb = $signed({3'b0, w_exp16}) - 8'sd15;
    end
    w_te = w_unb + (fmt ? 8'sd7 : 8'sd15);
    w_sh = (w_te > 8'sd0) ? 5'd0 : (5'd1 - w_te[4:0]);
    // 21 zero pad bits absorb the largest denormalizing shift without loss
    w_ext = {w_sig, 21'b0} >> w_sh;
    w_ef  = w_ext[31] ? w_te[5:0] : 6'd0;

    w_rnd4 = w_ext[27] & ((|w_ext[26:0]) | w_ext[28]);
    w_rnd5 = w_ext[28] & ((|w_ext[27:0]) | w_ext[29]);
    // exp and mantissa added as one field so a mantissa carry bumps the exponent
    w_q4 = {w_ef, w_ext[30:28]} + {8'd0, w_rnd4};
    w_q5 = {w_ef, w_ext[30:29]} + {7'd0, w_rnd5};

    if (fmt) begin
      if (w_q4[8:3] >= 6'd15) w_fp8 = {w_sign, 7'h78};
      else                    w_fp8 = {w_sign, w_q4[6:0]};
    end else begin
      if (w_q5[7:2] >= 6'd31) w_fp8 = {w_sign, 7'h7C};
      else                    w_fp8 = {w_sign, w_q5[6:0]};
    end

    if (w_exp16 == 5'h1F) begin
      if (w_man16 != 10'd0) w_fp8 = NAN_CANON;
      else                  w_fp8 = fmt ? {w_sign, 7'h78} : {w_sign, 7'h7C};
    end
  end

  assign in_ready = (r_state == S_IDLE) ||
                    (((r_state == S_BYTE) || (r_state == S_LO)) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= 8'd0;
      r_lo        <= 8'd0;
    end else begin
      case (r_state)
        S_HI: begin
          if (w_xfer) begin
            r_state    <= S_LO;
            r_out_data <= r_lo;
            r_out_last <= 1'b1;
          end
        end
        default: begin
          // IDLE, BYTE and LO share the load path; in_ready already gates accept
          if (w_accept) begin
            r_out_valid <= 1'b1;
            if (wide) begin
              r_state    <= S_HI;
              r_out_data <= in_data[15:8];
              r_lo       <= in_data[7:0];
              r_out_last <= 1'b0;
            end else begin
              r_state    <= S_BYTE;
              r_out_data <= w_fp8;
              r_out_last <= 1'b1;
            end
          end else if (w_xfer) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fp_result_pack.sv
// Scoreboard bench for fp_result_pack: expected bytes queued at accept, checked on transfer.
module tb_fp_result_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        fmt = 1'b0;
  logic        wide = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  fp_result_pack #(.NAN_CANON(8'h7F)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fmt(fmt), .wide(wide),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Output monitor: every transfer pops and compares one {last,data} entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [8:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got data=%02h last=%0b, none expected", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          bad++;
          $display("FAIL out_byte: got data=%02h last=%0b, want data=%02h last=%0b",
                   out_data, out_last, e[7:0], e[8]);
        end else begin
          $display("xfer data=%02h last=%0b", out_data, out_last);
        end
      end
    end
  end

  // Offer one word; push expected bytes when it is accepted (push=0 skips the scoreboard)
  task automatic send(input logic [15:0] d, input logic f, input logic w,
                      input logic [7:0] e8, input logic push);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; fmt = f; wide = w;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: word %04h never accepted, in_ready=%0b want 1", d, in_ready);
    end else if (push) begin
      if (w) begin
        exp_q.push_back({1'b0, d[15:8]});
        exp_q.push_back({1'b1, d[7:0]});
      end else begin
        exp_q.push_back({1'b1, e8});
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d bytes still pending, want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", out_data); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b want 0", out_last); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(16'h3C00, 1'b1, 1'b0, 8'h38, 1'b1);
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid: got %0b want 1", out_valid); end
    if (out_last !== 1'b1) begin bad++; $display("FAIL latency_last: got %0b want 1", out_last); end
    @(posedge clk); #1;
    send(16'h3C00, 1'b0, 1'b0, 8'h3C, 1'b1);
    drain();
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    send(16'h3C80, 1'b0, 1'b0, 8'h3C, 1'b1);
    send(16'h3D80, 1'b0, 1'b0, 8'h3E, 1'b1);
    send(16'h3D80, 1'b1, 1'b0, 8'h3B, 1'b1);
    drain();
  endtask

  task automatic test_boundaries();
    logic [15:0] vin [12];
    logic        vfmt[12];
    logic [7:0]  vexp[12];
    vin = '{16'h5B80, 16'h5BC0, 16'h5CB0, 16'h7E00, 16'h7E00, 16'h8000,
            16'h1800, 16'h1400, 16'hBC00, 16'h7C00, 16'h7B80, 16'h7B00};
    vfmt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vexp = '{8'h77, 8'h78, 8'h78, 8'h7F, 8'h7F, 8'h80,
             8'h01, 8'h00, 8'hB8, 8'h7C, 8'h7C, 8'h7B};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(vin[i], vfmt[i], 1'b0, vexp[i], 1'b1);
    drain();
  endtask

  task automatic test_wide();
    out_ready = 1'b0;
    send(16'hABCD, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %0b want 1", out_valid); end
      if (out_data !== 8'hAB) begin bad++; $display("FAIL hold_data: got %02h want AB", out_data); end
      if (out_last !== 1'b0) begin bad++; $display("FAIL hold_last: got %0b want 0", out_last); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready: got %0b want 0", in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin [4];
    logic [7:0]  vexp[4];
    vin  = '{16'h3C00, 16'h3D80, 16'h5B80, 16'hBC00};
    vexp = '{8'h38, 8'h3B, 8'h77, 8'hB8};
    out_ready = 1'b1;
    in_valid = 1'b1; fmt = 1'b1; wide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = vin[i];
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: word %0d got %0b want 1", i, in_ready); end
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble: word %0d out_valid=%0b want 1", i, out_valid); end
      end
      exp_q.push_back({1'b1, vexp[i]});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last: out_valid=%0b want 1", out_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(16'h1234, 1'b0, 1'b1, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_boundaries();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_result_pack.md
Name: fp_result_pack

Overview:
- Output-side counterpart to the FP8-multiply / FP16-accumulate pipeline.
- Accepts FP16 accumulator results and re-encodes each one to FP8, either E4M3 or E5M2.
- In wide mode it passes the raw FP16 value through instead, split into two bytes.
- Bytes leave through a valid/ready byte stream toward the chip's 8-bit output pins.

Parameters:
- NAN_CANON, 8'h7F, FP8 pattern emitted for any NaN input, in both formats.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data/fmt/wide are offered this cycle
- in_ready  out  1  block can accept a word this cycle
- in_data  in  16  FP16 value: sign[15], exp[14:10] bias 15, man[9:0]
- fmt  in  1  1 = E4M3 (exp[6:3] bias 7); 0 = E5M2 (exp[6:2] bias 15)
- wide  in  1  1 = emit raw FP16 as two bytes, high byte first; 0 = emit one FP8 byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts out_data this cycle
- out_data  out  8  output byte
- out_last  out  1  marks the final byte of the current word

Behaviour:
- Reset, one clock and synchronous active-high: out_valid=0, out_data=0, out_last=0, in_ready=1, FSM=IDLE. Reset mid-word drops any pending byte.
- Handshakes:
  - Input accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
- FSM states:
  - IDLE: no data held. in_ready=1.
  - BYTE: holding a single FP8 byte, out_last=1.
  - HI: holding in_data[15:8], out_last=0.
  - LO: holding in_data[7:0], out_last=1.
- Transitions:
  - IDLE accept → BYTE (wide=0) or HI (wide=1).
  - HI transfer → LO.
  - BYTE or LO transfer with a simultaneous accept → BYTE/HI for the new word (no bubble).
  - BYTE or LO transfer with no accept → IDLE.
  - in_ready = (state==IDLE) || ((state==BYTE || state==LO) && out_ready).
- Latency:
  - An accept in cycle N gives out_valid=1 in cycle N+1.
  - Throughput is 1 word/cycle narrow, 1 word/2 cycles wide.
- fmt and wide are sampled only on accept. The low byte for wide mode is registered at accept.
- FP16→FP8 conversion is combinational on in_data and registered on accept:
  - Sign passes through unchanged, including on zero and inf.
  - NaN (exp=31, man≠0) → NAN_CANON. Inf → sign,exp all ones,man 0 (E4M3 0x78/0xF8, E5M2 0x7C/0xFC).
  - Otherwise, rebias to the target format (E4M3 subtract 8, E5M2 unchanged).
  - Normalize FP16 subnormals before rebiasing.
  - Target exp ≤ 0 → denormalize with a right shift, folding shifted-out bits into a sticky bit.
  - Keep 3 (E4M3) or 2 (E5M2) mantissa bits and round to nearest even using guard plus round|sticky, the same rule as the pipeline.
  - A mantissa carry increments the exponent. A subnormal rounding up to min normal is a valid result.
- Saturation and underflow:
  - Post-round exp ≥ 15 (E4M3) or ≥ 31 (E5M2) → signed inf.
  - This means FP16 ≥ 248 → E4M3 inf, and FP16 ≥ 61440 → E5M2 inf.
  - A value that rounds to zero → signed zero. There is no flush of representable subnormals.

Test Plan:
- Reset, then 1.0 (0x3C00) narrow: fmt=1 → 0x38; fmt=0 → 0x3C. out_last=1, out_valid in the cycle after accept.
- Rounding:
  - 0x3C80 (1.125), E5M2 → 0x3C (tie to even).
  - 0x3D80 (1.375), E5M2 → 0x3E (tie rounds up to even).
  - 0x3D80, E4M3 → 0x3B (exact).
- Boundaries:
  - E4M3: 0x5B80 (240) → 0x77; 0x5BC0 (248) → 0x78; 0x5CB0 (300) → 0x78.
  - 0x7E00 (NaN) → 0x7F in both formats; 0x8000 → 0x80.
  - E4M3 subnormal: 0x1800 (2^-9) → 0x01; 0x1400 (2^-10) → 0x00.
- Wide mode: 0xABCD → byte 0xAB (out_last=0) then 0xCD (out_last=1). Hold out_ready=0 for 3 cycles on the high byte: data stable, in_ready=0.
- Back-to-back: 4 narrow words with in_valid and out_ready held high → 4 consecutive output bytes with no bubble, in_ready=1 throughout.
- Assert rst while in state HI → next cycle out_valid=0, in_ready=1; the low byte is never emitted.
